// File: rtl/bypass_hazard_unit.sv
// Operand/store-data forwarding selects plus load-use and mult/div scoreboard stall generation.
// Optional macro BYPASS_R30_EN adds setx (writes r30) and bex (reads r30) to the hazard decode.
module bypass_hazard_unit #(
  parameter int INSN_W     = 32,
  parameter int REG_W      = 5,
  parameter int MD_MAX_CYC = 40,
  parameter int CNT_W      = 6
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [INSN_W-1:0] fd_insn,
  input  logic [INSN_W-1:0] dx_insn,
  input  logic [INSN_W-1:0] xm_insn,
  input  logic [INSN_W-1:0] mw_insn,
  input  logic              advance,
  input  logic              md_ready,
  output logic [1:0]        sel_a,
  output logic [1:0]        sel_b,
  output logic              wm_bypass,
  output logic              stall,
  output logic              md_busy,
  output logic [REG_W-1:0]  md_rd,
  output logic              md_timeout
);

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_JAL   = 5'b00011;
`ifdef BYPASS_R30_EN
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] OP_BEX   = 5'b10110;
`endif
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MD_MAX_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_MAX_CYC - 1);

  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} md_state_t;

  function automatic logic [4:0] op_of(input logic [INSN_W-1:0] i);
    return i[INSN_W-1 -: 5];
  endfunction

  function automatic logic is_md(input logic [INSN_W-1:0] i);
    return (op_of(i) == OP_RTYPE) && (i[6:3] == 4'b0011);
  endfunction

  // Destination register written by the instruction, zero when it writes nothing.
  function automatic logic [REG_W-1:0] dest_of(input logic [INSN_W-1:0] i);
    case (op_of(i))
      OP_RTYPE, OP_ADDI, OP_LW: return REG_W'(i[26:22]);
      OP_JAL:                   return REG_W'(5'd31);
`ifdef BYPASS_R30_EN
      OP_SETX:                  return REG_W'(5'd30);
`endif
      default:                  return '0;
    endcase
  endfunction

  // Mult/div results arrive only through the scoreboard, never from XM/MW.
  function automatic logic [REG_W-1:0] fwd_dest_of(input logic [INSN_W-1:0] i);
    if (is_md(i)) begin
      return '0;
    end else begin
      return dest_of(i);
    end
  endfunction

  function automatic logic [REG_W-1:0] src_a_of(input logic [INSN_W-1:0] i);
    case (op_of(i))
      OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BNE, OP_BLT: return REG_W'(i[21:17]);
`ifdef BYPASS_R30_EN
      OP_BEX:                                          return REG_W'(5'd30);
`endif
      default:                                         return '0;
    endcase
  endfunction

  // Second source: rs2 for non-shift r-types, the rd field for store/branch/jr.
  function automatic logic [REG_W-1:0] src_b_of(input logic [INSN_W-1:0] i);
    case (op_of(i))
      OP_RTYPE: begin
        if (i[6:3] == 4'b0010) begin
          return '0;
        end else begin
          return REG_W'(i[16:12]);
        end
      end
      OP_SW, OP_BNE, OP_BLT, OP_JR: return REG_W'(i[26:22]);
      default:                      return '0;
    endcase
  endfunction

  function automatic logic hit(input logic [REG_W-1:0] r, input logic [REG_W-1:0] m);
    return (r != '0) && (r == m);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src,
                                         input logic [REG_W-1:0] xm_d,
                                         input logic [REG_W-1:0] mw_d);
    if (hit(src, xm_d)) begin
      return 2'b01;
    end else if (hit(src, mw_d)) begin
      return 2'b10;
    end else begin
      return 2'b00;
    end
  endfunction

  md_state_t        state_r;
  logic [REG_W-1:0] md_rd_r;
  logic [CNT_W-1:0] cnt_r;
  logic             timeout_r;

  logic [REG_W-1:0] xm_fwd_s, mw_fwd_s, dx_dest_s, fd_a_s, fd_b_s, dx_a_s, dx_b_s;
  logic             load_use_s, md_stall_s, launch_s;

  assign xm_fwd_s  = fwd_dest_of(xm_insn);
  assign mw_fwd_s  = fwd_dest_of(mw_insn);
  assign dx_dest_s = dest_of(dx_insn);
  assign fd_a_s    = src_a_of(fd_insn);
  assign fd_b_s    = src_b_of(fd_insn);
  assign dx_a_s    = src_a_of(dx_insn);
  assign dx_b_s    = src_b_of(dx_insn);
  assign launch_s  = is_md(dx_insn) && advance;

  assign sel_a     = fwd_sel(dx_a_s, xm_fwd_s, mw_fwd_s);
  assign sel_b     = fwd_sel(dx_b_s, xm_fwd_s, mw_fwd_s);
  assign wm_bypass = (op_of(xm_insn) == OP_SW) && hit(REG_W'(xm_insn[26:22]), mw_fwd_s);

  assign load_use_s = (op_of(dx_insn) == OP_LW) &&
                      (hit(fd_a_s, dx_dest_s) || hit(fd_b_s, dx_dest_s));

  assign md_stall_s = (state_r == PEND) &&
                      (hit(fd_a_s, md_rd_r) || hit(fd_b_s, md_rd_r) ||
                       hit(dx_a_s, md_rd_r) || hit(dx_b_s, md_rd_r) ||
                       hit(dest_of(fd_insn), md_rd_r) || hit(dx_dest_s, md_rd_r) ||
                       is_md(dx_insn));

  assign stall      = load_use_s || md_stall_s;
  assign md_busy    = (state_r == PEND);
  assign md_rd      = md_rd_r;
  assign md_timeout = timeout_r;

  // Mult/div scoreboard: pending entry, latency counter and sticky timeout.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      md_rd_r   <= '0;
      cnt_r     <= '0;
      timeout_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (launch_s) begin
            state_r <= PEND;
            md_rd_r <= dx_dest_s;
            cnt_r   <= '0;
          end else begin
            state_r <= IDLE;
          end
        end
        PEND: begin
          if (md_ready && launch_s) begin
            md_rd_r <= dx_dest_s;
            cnt_r   <= '0;
          end else if (md_ready) begin
            state_r <= IDLE;
          end else begin
            if (cnt_r != CNT_MAX) begin
              cnt_r <= cnt_r + CNT_W'(1);
            end else begin
              cnt_r <= cnt_r;
            end
            if (cnt_r >= CNT_LAST) begin
              timeout_r <= 1'b1;
            end else begin
              timeout_r <= timeout_r;
            end
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bypass_hazard_unit.sv
// Directed-vector bench: stimulus pushes expected outputs into a queue, a negedge monitor pops and compares.
module tb_bypass_hazard_unit;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] fd_insn, dx_insn, xm_insn, mw_insn;
  logic        advance = 1'b0;
  logic        md_ready = 1'b0;
  logic [1:0]  sel_a, sel_b;
  logic        wm_bypass, stall, md_busy, md_timeout;
  logic [4:0]  md_rd;

  localparam logic [31:0] NOP = 32'hF800_0000;

  typedef struct {
    string       name;
    logic [12:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  bypass_hazard_unit dut (
    .clock(clock), .reset_n(reset_n),
    .fd_insn(fd_insn), .dx_insn(dx_insn), .xm_insn(xm_insn), .mw_insn(mw_insn),
    .advance(advance), .md_ready(md_ready),
    .sel_a(sel_a), .sel_b(sel_b), .wm_bypass(wm_bypass), .stall(stall),
    .md_busy(md_busy), .md_rd(md_rd), .md_timeout(md_timeout)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] ins(input logic [4:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic [4:0] alu);
    return {op, rd, rs1, rs2, 5'd0, alu, 2'd0};
  endfunction

  function automatic logic [12:0] ex(input logic [1:0] sa, input logic [1:0] sb,
                                     input logic wm, input logic st, input logic bz,
                                     input logic [4:0] rd, input logic to);
    return {sa, sb, wm, st, bz, rd, to};
  endfunction

  // Compare every queued expectation against the DUT on the falling edge.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [12:0] act;
      e   = exp_q.pop_front();
      act = {sel_a, sel_b, wm_bypass, stall, md_busy, md_rd, md_timeout};
      n_vec++;
      if (act !== e.v) begin
        n_bad++;
        $display("FAIL %s: got sa=%b sb=%b wm=%b st=%b bz=%b rd=%0d to=%b, want sa=%b sb=%b wm=%b st=%b bz=%b rd=%0d to=%b",
                 e.name, act[12:11], act[10:9], act[8], act[7], act[6], act[5:1], act[0],
                 e.v[12:11], e.v[10:9], e.v[8], e.v[7], e.v[6], e.v[5:1], e.v[0]);
      end
    end
  end

  task automatic step(input string nm, input logic [31:0] f, input logic [31:0] d,
                      input logic [31:0] x, input logic [31:0] m,
                      input logic adv, input logic rdy, input logic [12:0] e);
    exp_t t;
    @(posedge clock);
    #1;
    fd_insn = f; dx_insn = d; xm_insn = x; mw_insn = m;
    advance = adv; md_ready = rdy;
    t.name = nm; t.v = e;
    exp_q.push_back(t);
  endtask

  localparam logic [4:0] RT = 5'b00000;

  initial begin
    logic [31:0] add5a, add5b, add7, sub2, mul9, addr9, setx, bex;
    exp_t t;
    logic [1:0] r30_sel;
    fd_insn = NOP; dx_insn = NOP; xm_insn = NOP; mw_insn = NOP;
    add5a = ins(RT, 5'd5, 5'd1, 5'd2, 5'd0);
    add5b = ins(RT, 5'd5, 5'd3, 5'd4, 5'd0);
    add7  = ins(RT, 5'd7, 5'd5, 5'd6, 5'd0);
    sub2  = ins(RT, 5'd2, 5'd4, 5'd3, 5'd1);
    mul9  = ins(RT, 5'd9, 5'd1, 5'd2, 5'd6);
    addr9 = ins(RT, 5'd1, 5'd9, 5'd2, 5'd0);

    step("reset", NOP, NOP, NOP, NOP, 1'b0, 1'b0, ex(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0));
    @(negedge clock);
    #1 reset_n = 1'b1;

    step("mx_prio", NOP, add7, add5a, add5b, 1'b1, 1'b0, ex(2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0));
    step("wx_after_retire", NOP, add7, NOP, add5b, 1'b1, 1'b0, ex(2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0));
    step("wx_sel_b", NOP, ins(RT, 5'd7, 5'd1, 5'd5, 5'd0), NOP, add5b, 1'b1, 1'b0,
         ex(2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0));
    step("shift_no_rt", NOP, ins(RT, 5'd7, 5'd1, 5'd5, 5'd4), add5a, NOP, 1'b1, 1'b0,
         ex(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0));
    step("reg0", NOP, ins(RT, 5'd1, 5'd0, 5'd0, 5'd0), ins(5'b00101, 5'd0, 5'd3, 5'd0, 5'd0), NOP,
         1'b1, 1'b0, ex(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0));
    step("wm_bypass", NOP, NOP, ins(5'b00111, 5'd8, 5'd2, 5'd0, 5'd0), ins(5'b01000, 5'd8, 5'd1, 5'd0, 5'd0),
         1'b1, 1'b0, ex(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0));
    step("bne_rd_mx", NOP, ins(5'b00010, 5'd5, 5'd1, 5'd0, 5'd0), add5a, NOP, 1'b1, 1'b0,
         ex(2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0));
    step("md_not_fwd", NOP, add7, ins(RT, 5'd5, 5'd1, 5'd2, 5'd6), NOP, 1'b1, 1'b0,
         ex(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0));
    step("jal_r31", NOP, ins(RT, 5'd7, 5'd31, 5'd0, 5'd0), ins(5'b00011, 5'd0, 5'd0, 5'd0, 5'd0), NOP,
         1'b1, 1'b0, ex(2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0));

    step("load_use", sub2, ins(5'b01000, 5'd4, 5'd1, 5'd0, 5'd0), NOP, NOP, 1'b0, 1'b0,
         ex(2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0));
    step("load_bubble", sub2, NOP, ins(5'b01000, 5'd4, 5'd1, 5'd0, 5'd0), NOP, 1'b1, 1'b0,
         ex(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0));
    step("load_wx", NOP, sub2, NOP, ins(5'b01000, 5'd4, 5'd1, 5'd0, 5'd0), 1'b1, 1'b0,
         ex(2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0));

    step("md_no_adv", addr9, mul9, NOP, NOP, 1'b0, 1'b0, ex(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0));
    step("md_launch", addr9, mul9, NOP, NOP, 1'b1, 1'b0, ex(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0));
    for (int k = 0; k < 4; k++)
      step("md_pend_stall", NOP, addr9, mul9, NOP, 1'b0, 1'b0, ex(2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0));
    step("md_ready_cyc", NOP, addr9, mul9, NOP, 1'b0, 1'b1, ex(2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0));
    step("md_released", NOP, addr9, mul9, NOP, 1'b0, 1'b0, ex(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd9, 1'b0));
    step("ready_idle", NOP, addr9, mul9, NOP, 1'b0, 1'b1, ex(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd9, 1'b0));
    step("ready_idle_hold", NOP, NOP, NOP, NOP, 1'b0, 1'b0, ex(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd9, 1'b0));

    step("div_launch", NOP, ins(RT, 5'd10, 5'd1, 5'd2, 5'd7), NOP, NOP, 1'b1, 1'b0,
         ex(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd9, 1'b0));
    step("ready_and_launch", NOP, ins(RT, 5'd11, 5'd1, 5'd2, 5'd6), NOP, NOP, 1'b1, 1'b1,
         ex(2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 5'd10, 1'b0));
    step("relaunch_rd", NOP, NOP, NOP, NOP, 1'b0, 1'b0, ex(2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 5'd11, 1'b0));
    step("waw_stall", ins(5'b00101, 5'd11, 5'd1, 5'd0, 5'd0), NOP, NOP, NOP, 1'b0, 1'b0,
         ex(2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 5'd11, 1'b0));
    // Counter cleared on the relaunch edge; it reaches 40 on the edge after pending vector 40.
    for (int k = 3; k <= 45; k++)
      step("timeout", NOP, NOP, NOP, NOP, 1'b0, 1'b0,
           ex(2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 5'd11, (k >= 41) ? 1'b1 : 1'b0));
    step("timeout_stall", ins(RT, 5'd1, 5'd11, 5'd2, 5'd0), NOP, NOP, NOP, 1'b0, 1'b0,
         ex(2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 5'd11, 1'b1));

    @(posedge clock);
    #2 reset_n = 1'b0;
    t.name = "async_reset"; t.v = ex(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    exp_q.push_back(t);
    @(negedge clock);
    #1 reset_n = 1'b1;

    setx = ins(5'b10101, 5'd0, 5'd0, 5'd0, 5'd0);
    bex  = ins(5'b10110, 5'd0, 5'd0, 5'd0, 5'd0);
`ifdef BYPASS_R30_EN
    r30_sel = 2'b01;
`else
    r30_sel = 2'b00;
`endif
    step("r30_setx_bex", NOP, bex, setx, NOP, 1'b1, 1'b0, ex(r30_sel, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0));

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clock);
    #1;
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/bypass_hazard_unit.md
# bypass_hazard_unit

Parametrised successor to the pipeline forwarding logic. It produces the MX/WX operand-forwarding selects and the WM store-data bypass for the DX/XM stages. It also adds sequential hazard tracking: a load-use stall and a one-entry scoreboard for the multi-cycle mult/div unit, with latency counting and timeout detection. It sits beside the FD/DX/XM/MW latches and drives the operand muxes, the store-data mux, and the pipeline stall line.

## Interface
Parameters:
- INSN_W, 32, instruction width; opcode at [INSN_W-1 -: 5], rd at [26:22], rs1 at [21:17], rs2 at [16:12], ALU op at [6:2].
- REG_W, 5, register-index width; register 0 is never forwarded or scoreboarded.
- MD_MAX_CYC, 40, cycles a mult/div may stay pending before timeout.
- CNT_W, 6, width of the pending-cycle counter; must satisfy 2^CNT_W > MD_MAX_CYC.

Ports:
- clock, in, 1, sole clock, rising edge.
- reset_n, in, 1, asynchronous active-low reset.
- fd_insn, dx_insn, xm_insn, mw_insn, in, INSN_W each, stage instruction words.
- advance, in, 1, pipeline moves this cycle (DX accepted into XM).
- md_ready, in, 1, one-cycle pulse: mult/div result valid.
- sel_a, out, 2, ALU A select: 00 regfile, 01 MX, 10 WX.
- sel_b, out, 2, ALU B / branch-rd select, same encoding.
- wm_bypass, out, 1, store data taken from MW result.
- stall, out, 1, freeze FD/DX and insert bubble into XM.
- md_busy, out, 1, scoreboard entry valid.
- md_rd, out, REG_W, destination register of the pending mult/div.
- md_timeout, out, 1, sticky error flag.

## Operation
- Writers: r-type 00000, addi 00101, lw 01000; jal 00011 writes r31.
- rs1 readers: r-type, addi, lw, sw, bne, blt.
- rt readers: r-type, excluding shifts (ALU op 0010x).
- rd readers: sw 00111, bne 00010, blt 00110, jr 00100.
- sel_a: 01 if the DX rs1 reader's rs1 equals the XM writer's rd and is non-zero; else 10 if it matches the MW writer; else 00. MX has priority over WX.
- sel_b: same rule, using rs2 for rt readers and rd for rd readers.
- wm_bypass: XM is sw, MW is a writer, xm_rd == mw_rd, and the register is non-zero.
- A mult/div (r-type, ALU op 00110/00111) never forwards from XM or MW. Its result comes only via the scoreboard.
- Load-use stall: DX is lw, and an FD reader's source equals dx_rd (non-zero).
- Scoreboard states: IDLE and PEND.
  - IDLE -> PEND when DX holds a mult/div and advance=1. This latches md_rd=dx_rd and clears the counter.
  - PEND -> IDLE on md_ready.
  - PEND holds otherwise, and the counter increments, saturating at MD_MAX_CYC.
- md_stall is asserted in PEND when either:
  - any FD or DX source, or the FD/DX rd of a writer (WAW), equals md_rd; or
  - DX holds another mult/div (structural hazard).
- stall = load-use OR md_stall.
- md_timeout is set when the counter reaches MD_MAX_CYC while in PEND. It clears only on reset.

## Timing
- Reset: sel_a=00, sel_b=00, wm_bypass=0, stall=0, md_busy=0, md_rd=0, md_timeout=0, counter=0, state IDLE.
- sel_a, sel_b, wm_bypass and stall are combinational from the inputs and the current state, valid in the same cycle.
- md_busy rises on the edge after the launch cycle. It falls on the edge after md_ready.
- Simultaneous md_ready and new launch in the same cycle: stay in PEND, load the new rd, clear the counter.
- md_ready while IDLE is ignored.
- advance=0 while DX holds a mult/div: no launch.
- A reset assertion mid-PEND immediately returns to IDLE and drops stall.
- The counter does not wrap; it saturates at MD_MAX_CYC.

## Configuration
- Macro BYPASS_R30_EN.
- Defined: setx 10101 is a writer of r30, and bex 10110 is an rs1 reader of r30. Both participate in MX/WX forwarding and in the load-use and scoreboard compares.
- Undefined: setx and bex are treated as non-writers and non-readers; r30 hazards must be avoided by software.

## Test plan
- Forward priority: XM add r5, MW add r5, DX add r7,r5,r6 -> sel_a=01, sel_b=00; retire XM -> sel_a=10.
- Register 0: XM addi r0, DX add r1,r0,r0 -> sel_a=00, sel_b=00, stall=0.
- Load-use: DX lw r4, FD sub r2,r4,r3 -> stall=1 for one cycle. On the next cycle lw is in XM with a bubble in DX, stall=0, and the sub then reaches DX with sel_a=10.
- Mult/div scoreboard: launch mul r9 with advance=1, FD add r1,r9,r2 -> md_busy=1, md_rd=9, stall=1 until md_ready pulses 5 cycles later. md_busy=0 one edge after md_ready.
- Timeout: launch div with md_ready held low for MD_MAX_CYC cycles -> md_timeout=1 and stays 1. Asserting reset_n=0 mid-PEND -> all outputs 0 asynchronously.
- With BYPASS_R30_EN defined: XM setx, DX bex -> sel_a=01. Rebuilt without the macro -> sel_a=00.
